// File: rtl/cpu301_pkg.sv
// Shared constants for the 301 RISC datapath and its sequencer: word width,
// register file geometry and ALU opcode encodings.
package cpu301_pkg;

    localparam int DW       = 16;
    localparam int RF_AW    = 3;
    localparam int RF_DEPTH = 8;

    localparam logic [3:0] ALU_PASS_S = 4'b0000;
    localparam logic [3:0] ALU_PASS_R = 4'b0001;
    localparam logic [3:0] ALU_INC    = 4'b0010;
    localparam logic [3:0] ALU_DEC    = 4'b0011;
    localparam logic [3:0] ALU_ADD    = 4'b0100;
    localparam logic [3:0] ALU_SUB    = 4'b0101;
    localparam logic [3:0] ALU_SHR    = 4'b0110;
    localparam logic [3:0] ALU_SHL    = 4'b0111;
    localparam logic [3:0] ALU_AND    = 4'b1000;
    localparam logic [3:0] ALU_OR     = 4'b1001;
    localparam logic [3:0] ALU_XOR    = 4'b1010;
    localparam logic [3:0] ALU_NOT    = 4'b1011;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the 301 datapath. Works on a 17-bit internal value so
// that the carry, borrow and shift-out bit all land in the top bit.
module cpu_alu
    import cpu301_pkg::*;
(
    input  logic [DW-1:0] r,
    input  logic [DW-1:0] s,
    input  logic [3:0]    alu_op,
    output logic [DW-1:0] result,
    output logic          n,
    output logic          z,
    output logic          c
);

    logic [DW:0] wide;

    always_comb begin
        wide = '0;
        case (alu_op)
            ALU_PASS_S: wide = {1'b0, s};
            ALU_PASS_R: wide = {1'b0, r};
            ALU_INC:    wide = {1'b0, s} + (DW+1)'(1);
            // Borrow out of the 17-bit subtract sets the top bit.
            ALU_DEC:    wide = {1'b0, s} - (DW+1)'(1);
            ALU_ADD:    wide = {1'b0, r} + {1'b0, s};
            ALU_SUB:    wide = {1'b0, r} - {1'b0, s};
            ALU_SHR:    wide = {s[0], 1'b0, s[DW-1:1]};
            ALU_SHL:    wide = {s, 1'b0};
            ALU_AND:    wide = {1'b0, r & s};
            ALU_OR:     wide = {1'b0, r | s};
            ALU_XOR:    wide = {1'b0, r ^ s};
            ALU_NOT:    wide = {1'b0, ~s};
            default:    wide = '0;
        endcase
    end

    assign result = wide[DW-1:0];
    assign c      = wide[DW];
    assign n      = result[DW-1];
    assign z      = (result == '0);

endmodule

// File: rtl/cpu_exec_unit.sv
// 301 RISC execution datapath: PC, IR, 8x16 register file, ALU and muxes.
// Define CPU_EXEC_UNIT_DEBUG_PORT_EN for a third register read port (dbg_adr/dbg_data).
module cpu_exec_unit
    import cpu301_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [RF_AW-1:0]  W_Adr,
    input  logic [RF_AW-1:0]  R_Adr,
    input  logic [RF_AW-1:0]  S_Adr,
    input  logic              adr_sel,
    input  logic              s_sel,
    input  logic              pc_ld,
    input  logic              pc_inc,
    input  logic              pc_sel,
    input  logic              ir_ld,
    input  logic              rw_en,
    input  logic [3:0]        alu_op,
    input  logic [DW-1:0]     D_in,
`ifdef CPU_EXEC_UNIT_DEBUG_PORT_EN
    input  logic [RF_AW-1:0]  dbg_adr,
    output logic [DW-1:0]     dbg_data,
`endif
    output logic [DW-1:0]     Address,
    output logic [DW-1:0]     D_out,
    output logic [DW-1:0]     IR,
    output logic              N,
    output logic              Z,
    output logic              C
);

    logic [DW-1:0] regs [RF_DEPTH];
    logic [DW-1:0] pc;
    logic [DW-1:0] ir_q;
    logic [DW-1:0] pc_next;
    logic [DW-1:0] reg_r;
    logic [DW-1:0] reg_s;
    logic [DW-1:0] alu_out;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] branch_ofs;

    assign reg_r = regs[R_Adr];
    assign reg_s = regs[S_Adr];

    cpu_alu u_alu (
        .r      (reg_r),
        .s      (reg_s),
        .alu_op (alu_op),
        .result (alu_out),
        .n      (N),
        .z      (Z),
        .c      (C)
    );

    assign wr_data = s_sel ? D_in : alu_out;

    // Write lands on the edge; reads in the same cycle still see the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (rw_en) begin
            regs[W_Adr] <= wr_data;
        end
    end

    // PC already points past the branch, so the offset is relative to PC+1 of the branch.
    assign branch_ofs = {{(DW-8){ir_q[7]}}, ir_q[7:0]};

    always_comb begin
        pc_next = pc;
        if (pc_ld) begin
            pc_next = pc_sel ? reg_s : (pc + branch_ofs);
        end else if (pc_inc) begin
            pc_next = pc + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc   <= '0;
            ir_q <= '0;
        end else begin
            pc <= pc_next;
            if (ir_ld) begin
                ir_q <= D_in;
            end
        end
    end

    assign Address = adr_sel ? reg_r : pc;
    assign D_out   = reg_s;
    assign IR      = ir_q;

`ifdef CPU_EXEC_UNIT_DEBUG_PORT_EN
    assign dbg_data = regs[dbg_adr];
`endif

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Bench for cpu_exec_unit: directed scenarios plus randomized cycles checked
// against an arithmetic reference model of PC, IR, registers and ALU.
module tb_cpu_exec_unit;
    import cpu301_pkg::*;

    logic        clk;
    logic        reset;
    logic [2:0]  W_Adr, R_Adr, S_Adr;
    logic        adr_sel, s_sel, pc_ld, pc_inc, pc_sel, ir_ld, rw_en;
    logic [3:0]  alu_op;
    logic [15:0] D_in;
    logic [15:0] Address, D_out, IR;
    logic        N, Z, C;
`ifdef CPU_EXEC_UNIT_DEBUG_PORT_EN
    logic [2:0]  dbg_adr;
    logic [15:0] dbg_data;
    assign dbg_adr = 3'd0;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] m_regs [8];
    logic [15:0] m_pc;
    logic [15:0] m_ir;
    logic [15:0] exp_q [$];

    cpu_exec_unit dut (
        .clk     (clk),
        .reset   (reset),
        .W_Adr   (W_Adr),
        .R_Adr   (R_Adr),
        .S_Adr   (S_Adr),
        .adr_sel (adr_sel),
        .s_sel   (s_sel),
        .pc_ld   (pc_ld),
        .pc_inc  (pc_inc),
        .pc_sel  (pc_sel),
        .ir_ld   (ir_ld),
        .rw_en   (rw_en),
        .alu_op  (alu_op),
        .D_in    (D_in),
`ifdef CPU_EXEC_UNIT_DEBUG_PORT_EN
        .dbg_adr (dbg_adr),
        .dbg_data(dbg_data),
`endif
        .Address (Address),
        .D_out   (D_out),
        .IR      (IR),
        .N       (N),
        .Z       (Z),
        .C       (C)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU from the opcode table, in plain integer arithmetic.
    function automatic logic [16:0] model_alu(logic [3:0] op, logic [15:0] r, logic [15:0] s);
        int ri, si, t;
        logic cy;
        ri = int'(r);
        si = int'(s);
        t  = 0;
        cy = 1'b0;
        case (op)
            4'd0:  t = si;
            4'd1:  t = ri;
            4'd2:  begin t = si + 1;  cy = (t > 65535); end
            4'd3:  begin t = si - 1;  cy = (si == 0);   end
            4'd4:  begin t = ri + si; cy = (t > 65535); end
            4'd5:  begin t = ri - si; cy = (ri < si);   end
            4'd6:  begin t = si / 2;  cy = ((si % 2) == 1); end
            4'd7:  begin t = si * 2;  cy = (si >= 32768); end
            4'd8:  t = ri & si;
            4'd9:  t = ri | si;
            4'd10: t = ri ^ si;
            4'd11: t = 65535 - si;
            default: t = 0;
        endcase
        t = ((t % 65536) + 65536) % 65536;
        return {cy, t[15:0]};
    endfunction

    // Driver tasks
    task automatic idle();
        W_Adr = 0; R_Adr = 0; S_Adr = 0;
        adr_sel = 0; s_sel = 0; pc_ld = 0; pc_inc = 0; pc_sel = 0;
        ir_ld = 0; rw_en = 0; alu_op = 0; D_in = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_pc = 16'h0;
        m_ir = 16'h0;
    endtask

    // Advance one clock edge, updating the model from the inputs driven now.
    task automatic model_step();
        logic [16:0] a;
        logic [15:0] wd;
        int imm, npc;
        a  = model_alu(alu_op, m_regs[R_Adr], m_regs[S_Adr]);
        wd = s_sel ? D_in : a[15:0];
        imm = m_ir[7] ? int'(m_ir[7:0]) - 256 : int'(m_ir[7:0]);
        if (pc_ld && pc_sel)  npc = int'(m_regs[S_Adr]);
        else if (pc_ld)       npc = (int'(m_pc) + imm + 65536) % 65536;
        else if (pc_inc)      npc = (int'(m_pc) + 1) % 65536;
        else                  npc = int'(m_pc);
        @(posedge clk);
        #1;
        if (rw_en) m_regs[W_Adr] = wd;
        if (ir_ld) m_ir = D_in;
        m_pc = npc[15:0];
    endtask

    task automatic write_reg(logic [2:0] w, logic [15:0] val);
        idle();
        rw_en = 1; s_sel = 1; W_Adr = w; D_in = val;
        model_step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (Address !== 16'h0000) begin errors++; $display("FAIL reset_address: got %h expected 0000", Address); end
        checks++; if (IR !== 16'h0000) begin errors++; $display("FAIL reset_ir: got %h expected 0000", IR); end
        checks++; if (D_out !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h expected 0000", D_out); end
        checks++; if ({N, Z, C} !== 3'b010) begin errors++; $display("FAIL reset_flags: got NZC=%b expected 010", {N, Z, C}); end
        for (int i = 0; i < 8; i++) begin
            adr_sel = 1; R_Adr = 3'(i); S_Adr = 3'(i);
            #1;
            checks++;
            if (Address !== 16'h0 || D_out !== 16'h0) begin
                errors++; $display("FAIL reset_reg%0d: got R=%h S=%h expected 0000", i, Address, D_out);
            end
        end
        idle();
    endtask

    task automatic test_pc_branch();
        idle();
        D_in = 16'hE0FA; ir_ld = 1; pc_inc = 1;
        model_step();
        idle(); #1;
        checks++; if (IR !== 16'hE0FA) begin errors++; $display("FAIL ir_load: got %h expected e0fa", IR); end
        checks++; if (Address !== 16'h0001) begin errors++; $display("FAIL pc_inc: got %h expected 0001", Address); end
        pc_ld = 1; pc_sel = 0;
        model_step();
        idle(); #1;
        checks++; if (Address !== 16'hFFFB) begin errors++; $display("FAIL pc_branch: got %h expected fffb", Address); end
        repeat (5) begin
            pc_inc = 1;
            model_step();
        end
        idle(); #1;
        checks++; if (Address !== 16'h0000) begin errors++; $display("FAIL pc_wrap: got %h expected 0000", Address); end
    endtask

    task automatic test_add();
        write_reg(3'd1, 16'hFFFF);
        write_reg(3'd2, 16'h0001);
        alu_op = ALU_ADD; R_Adr = 1; S_Adr = 2; W_Adr = 3; rw_en = 1;
        #1;
        checks++; if ({N, Z, C} !== 3'b011) begin errors++; $display("FAIL add_flags: got NZC=%b expected 011", {N, Z, C}); end
        model_step();
        idle();
        adr_sel = 1; R_Adr = 3; #1;
        checks++; if (Address !== 16'h0000) begin errors++; $display("FAIL add_result: got %h expected 0000", Address); end
        idle();
    endtask

    task automatic test_sub_shl();
        alu_op = ALU_SUB; R_Adr = 2; S_Adr = 1; W_Adr = 6; rw_en = 1;
        #1;
        checks++; if ({N, Z, C} !== 3'b001) begin errors++; $display("FAIL sub_flags: got NZC=%b expected 001", {N, Z, C}); end
        model_step();
        idle(); S_Adr = 6; #1;
        checks++; if (D_out !== 16'h0002) begin errors++; $display("FAIL sub_result: got %h expected 0002", D_out); end
        write_reg(3'd7, 16'h8001);
        alu_op = ALU_SHL; S_Adr = 7; W_Adr = 6; rw_en = 1;
        #1;
        checks++; if ({N, Z, C} !== 3'b001) begin errors++; $display("FAIL shl_flags: got NZC=%b expected 001", {N, Z, C}); end
        model_step();
        idle(); S_Adr = 6; #1;
        checks++; if (D_out !== 16'h0002) begin errors++; $display("FAIL shl_result: got %h expected 0002", D_out); end
        idle();
    endtask

    task automatic test_addr_pc_prio();
        write_reg(3'd4, 16'h0123);
        adr_sel = 1; R_Adr = 4; S_Adr = 4; #1;
        checks++; if (Address !== 16'h0123) begin errors++; $display("FAIL addr_reg_r: got %h expected 0123", Address); end
        checks++; if (D_out !== 16'h0123) begin errors++; $display("FAIL dout_reg_s: got %h expected 0123", D_out); end
        idle();
        pc_ld = 1; pc_sel = 1; pc_inc = 1; S_Adr = 4;
        model_step();
        idle(); #1;
        checks++; if (Address !== 16'h0123) begin errors++; $display("FAIL pc_load_priority: got %h expected 0123", Address); end
    endtask

    task automatic test_rw_bypass();
        idle();
        rw_en = 1; s_sel = 1; W_Adr = 5; D_in = 16'hBEEF; adr_sel = 1; R_Adr = 5;
        #1;
        checks++; if (Address !== 16'h0000) begin errors++; $display("FAIL rw_old_value: got %h expected 0000", Address); end
        model_step();
        checks++; if (Address !== 16'hBEEF) begin errors++; $display("FAIL rw_new_value: got %h expected beef", Address); end
        D_in = 16'h1234;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle();
        adr_sel = 1; R_Adr = 5; #1;
        checks++; if (Address !== 16'h0000) begin errors++; $display("FAIL reset_mid_write: got %h expected 0000", Address); end
        adr_sel = 0; #1;
        checks++; if (Address !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", Address); end
        idle();
    endtask

    task automatic test_ldi();
        idle();
        s_sel = 1; pc_inc = 1; rw_en = 1; W_Adr = 2; D_in = 16'h5A5A;
        model_step();
        idle(); S_Adr = 2; #1;
        checks++; if (D_out !== 16'h5A5A) begin errors++; $display("FAIL ldi_reg: got %h expected 5a5a", D_out); end
        checks++; if (Address !== 16'h0001) begin errors++; $display("FAIL ldi_pc: got %h expected 0001", Address); end
        idle();
    endtask

    task automatic test_random();
        logic [16:0] a;
        logic [15:0] got;
        for (int i = 0; i < 300; i++) begin
            W_Adr = 3'($urandom_range(0, 7));
            R_Adr = 3'($urandom_range(0, 7));
            S_Adr = 3'($urandom_range(0, 7));
            adr_sel = 1'($urandom_range(0, 1));
            s_sel   = 1'($urandom_range(0, 1));
            pc_ld   = ($urandom_range(0, 5) == 0);
            pc_inc  = 1'($urandom_range(0, 1));
            pc_sel  = 1'($urandom_range(0, 1));
            ir_ld   = ($urandom_range(0, 3) == 0);
            rw_en   = 1'($urandom_range(0, 1));
            alu_op  = 4'($urandom_range(0, 15));
            D_in    = 16'($urandom);
            #1;
            a = model_alu(alu_op, m_regs[R_Adr], m_regs[S_Adr]);
            exp_q.push_back(adr_sel ? m_regs[R_Adr] : m_pc);
            exp_q.push_back(m_regs[S_Adr]);
            exp_q.push_back(m_ir);
            got = exp_q.pop_front();
            checks++; if (Address !== got) begin errors++; $display("FAIL rand_address[%0d]: got %h expected %h", i, Address, got); end
            got = exp_q.pop_front();
            checks++; if (D_out !== got) begin errors++; $display("FAIL rand_dout[%0d]: got %h expected %h", i, D_out, got); end
            got = exp_q.pop_front();
            checks++; if (IR !== got) begin errors++; $display("FAIL rand_ir[%0d]: got %h expected %h", i, IR, got); end
            checks++;
            if ({N, Z, C} !== {a[15], a[15:0] == 16'h0, a[16]}) begin
                errors++;
                $display("FAIL rand_flags[%0d] op=%h: got NZC=%b expected %b", i, alu_op, {N, Z, C}, {a[15], a[15:0] == 16'h0, a[16]});
            end
            model_step();
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        model_reset();
        test_reset();
        test_pc_branch();
        test_add();
        test_sub_shl();
        test_addr_pc_prio();
        test_rw_bypass();
        test_ldi();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
